// File: rtl/entropy_encode_ac_level_pipe.sv
// AC level entropy encoder: context-adaptive rice / exp-golomb codewords,
// two-stage pipeline with a single global advance enable.
module entropy_encode_ac_level_pipe #(
  parameter int unsigned COEFF_W = 20,
  parameter int unsigned CODE_W  = 48,
  parameter int unsigned LEN_W   = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COEFF_W-1:0] in_coeff,
  input  logic                      in_first,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CODE_W-1:0]         out_code,
  output logic [LEN_W-1:0]          out_len,
  output logic                      out_last
);

  // v = |coeff|-1 always fits in COEFF_W-1 bits, even for the most negative value
  localparam int unsigned V_W   = COEFF_W - 1;
  // exp-golomb w = u + 2^k never exceeds 2^(COEFF_W-1)+3
  localparam int unsigned W_W   = COEFF_W;
  localparam int unsigned CTX_W = 4;
  localparam logic [CTX_W-1:0] CTX_FIRST = CTX_W'(1);
  localparam logic [CTX_W-1:0] CTX_SAT   = CTX_W'(8);

  // Elaboration-time parameter sanity
  if (COEFF_W < 4) begin : g_chk_coeff_w
    $error("COEFF_W must be >= 4");
  end
  if (CODE_W < 2 * COEFF_W + 1) begin : g_chk_code_w
    $error("CODE_W must be >= 2*COEFF_W+1");
  end
  if ((1 << LEN_W) <= CODE_W) begin : g_chk_len_w
    $error("2^LEN_W must exceed CODE_W");
  end

  logic                 w_en;
  logic                 w_accept;
  logic                 w_neg;
  logic                 w_nz;
  logic [V_W-1:0]       w_v;
  logic [CTX_W-1:0]     w_ctx_sat;
  logic [CTX_W-1:0]     w_ctx_use;

  logic [CTX_W-1:0]     r_ctx;
  logic                 r1_valid;
  logic                 r1_zero;
  logic [V_W-1:0]       r1_v;
  logic                 r1_s;
  logic [CTX_W-1:0]     r1_ctx;
  logic                 r1_last;

  logic                 w_rice;
  logic [1:0]           w_pre;
  logic [1:0]           w_k;
  logic [V_W-1:0]       w_u;
  logic [W_W-1:0]       w_w;
  logic [LEN_W-1:0]     w_n;
  logic [CODE_W-1:0]    w_code;
  logic [LEN_W-1:0]     w_len;

  logic                 r_out_valid;
  logic [CODE_W-1:0]    r_out_code;
  logic [LEN_W-1:0]     r_out_len;
  logic                 r_out_last;

  // Whole pipe advances together whenever the output slot is free or draining
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;
  assign w_accept = in_valid && w_en;

  // Magnitude minus one without overflow: for negatives -c-1 == ~c
  assign w_neg = in_coeff[COEFF_W-1];
  assign w_nz  = |in_coeff;
  assign w_v   = w_neg ? ~in_coeff[V_W-1:0] : (in_coeff[V_W-1:0] - V_W'(1));

  assign w_ctx_sat = (32'(w_v) >= 32'd8) ? CTX_SAT : CTX_W'(w_v);
  assign w_ctx_use = in_first ? CTX_FIRST : r_ctx;

  // Level context follows the last nonzero level; a block start forces it to 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctx <= CTX_FIRST;
    end else if (w_accept) begin
      if (w_nz) begin
        r_ctx <= w_ctx_sat;
      end else if (in_first) begin
        r_ctx <= CTX_FIRST;
      end
    end
  end

  // Stage 1: level, sign, selected codebook; zero non-last coeffs become bubbles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r1_valid <= 1'b0;
      r1_zero  <= 1'b0;
      r1_v     <= '0;
      r1_s     <= 1'b0;
      r1_ctx   <= CTX_FIRST;
      r1_last  <= 1'b0;
    end else if (w_en) begin
      r1_valid <= in_valid && (w_nz || in_last);
      r1_zero  <= !w_nz;
      r1_v     <= w_v;
      r1_s     <= w_neg;
      r1_ctx   <= w_ctx_use;
      r1_last  <= in_last;
    end
  end

  // Codebook decode: rice region, escape prefix, exp-golomb order and argument
  always_comb begin
    w_rice = 1'b0;
    w_pre  = 2'd0;
    w_k    = 2'd0;
    w_u    = r1_v;
    case (r1_ctx)
      4'd0: begin
        if (r1_v < V_W'(3)) begin
          w_rice = 1'b1;
        end else begin
          w_pre = 2'd3;
          w_k   = 2'd2;
          w_u   = r1_v - V_W'(3);
        end
      end
      4'd1: begin
        if (r1_v < V_W'(2)) begin
          w_rice = 1'b1;
        end else begin
          w_pre = 2'd2;
          w_k   = 2'd1;
          w_u   = r1_v - V_W'(2);
        end
      end
      4'd2: begin
        if (r1_v < V_W'(3)) begin
          w_rice = 1'b1;
        end else begin
          w_pre = 2'd3;
          w_k   = 2'd1;
          w_u   = r1_v - V_W'(3);
        end
      end
      4'd3:                   w_k = 2'd0;
      4'd4, 4'd5, 4'd6, 4'd7: w_k = 2'd1;
      default:                w_k = 2'd2;
    endcase
  end

  assign w_w = W_W'(w_u) + (W_W'(1) << w_k);

  // floor(log2 w): position of the leading one
  always_comb begin
    w_n = '0;
    for (int i = 0; i < int'(W_W); i++) begin
      if (w_w[i]) begin
        w_n = LEN_W'(i);
      end
    end
  end

  // Leading zeros carry no value, so the codeword value is just the terminating
  // 1 (rice) or w (exp-golomb), followed by the sign bit
  always_comb begin
    w_code = '0;
    w_len  = '0;
    if (r1_zero) begin
      w_code = '0;
      w_len  = '0;
    end else if (w_rice) begin
      w_code = CODE_W'(2) | CODE_W'(r1_s);
      w_len  = LEN_W'(r1_v) + LEN_W'(2);
    end else begin
      w_code = (CODE_W'(w_w) << 1) | CODE_W'(r1_s);
      w_len  = LEN_W'(w_pre) + (w_n << 1) - LEN_W'(w_k) + LEN_W'(2);
    end
  end

  // Stage 2: output register, held while downstream stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_code  <= '0;
      r_out_len   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r1_valid;
      if (r1_valid) begin
        r_out_code <= w_code;
        r_out_len  <= w_len;
        r_out_last <= r1_last;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_code  = r_out_code;
  assign out_len   = r_out_len;
  assign out_last  = r_out_last;

endmodule
